// File: rtl/rgu_spi_pkg.sv
// Shared types and constants for the RGU SPI master.
package rgu_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GUARD
  } spi_state_e;

  localparam int RGU_SPI_NUM_CS = 8;
  localparam logic [RGU_SPI_NUM_CS-1:0] RGU_SPI_CS_IDLE = 8'hFF;

endpackage

// File: rtl/rgu_spi_clkgen.sv
// Prescaler: paces every FSM phase in CLK_DIV-cycle steps and marks
// sclk rise/fall points while shifting.
module rgu_spi_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic shift,
  output logic tick_rise,
  output logic tick_fall,
  output logic phase_done
);

  logic [7:0] cnt;
  logic       ph;

  assign phase_done = en && (cnt == 8'(CLK_DIV - 1));
  // ph tracks the sclk level this window ends on, so alternate windows rise/fall
  assign tick_rise  = phase_done && shift && !ph;
  assign tick_fall  = phase_done && shift && ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else begin
      if (!en || phase_done) cnt <= '0;
      else                   cnt <= cnt + 8'd1;
      if (!shift)          ph <= 1'b0;
      else if (phase_done) ph <= ~ph;
    end
  end

endmodule

// File: rtl/rgu_spi_master.sv
// SPI mode-0 master: 1..DATA_W-bit transfers to one of eight active-low
// chip selects, with start/busy/done handshake and registered pins.
module rgu_spi_master
  import rgu_spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [2:0]                  cs_sel,
  input  logic [$clog2(DATA_W)-1:0]   len,
  input  logic [DATA_W-1:0]           tx_data,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        sclk,
  output logic [RGU_SPI_NUM_CS-1:0]   cs,
  output logic                        mosi,
  input  logic                        miso
);

  localparam int unsigned LW = $clog2(DATA_W);

  spi_state_e        state;
  logic [LW-1:0]     idx;
  logic [DATA_W-1:0] txsr;
  logic [DATA_W-1:0] rxsr;
  logic              tick_rise;
  logic              tick_fall;
  logic              phase_done;

  rgu_spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .en        (state != IDLE),
    .shift     (state == SHIFT),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .phase_done(phase_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      cs      <= RGU_SPI_CS_IDLE;
      mosi    <= 1'b0;
      idx     <= '0;
      txsr    <= '0;
      rxsr    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            // len-1 wraps to DATA_W-1 when len==0, giving the full-width count
            state <= LEAD;
            busy  <= 1'b1;
            cs    <= ~(RGU_SPI_NUM_CS'(1) << cs_sel);
            idx   <= len - LW'(1);
            txsr  <= tx_data;
            rxsr  <= '0;
            mosi  <= tx_data[len - LW'(1)];
          end
        end
        LEAD: begin
          if (phase_done) state <= SHIFT;
        end
        SHIFT: begin
          if (tick_rise) begin
            sclk <= 1'b1;
            rxsr <= {rxsr[DATA_W-2:0], miso};
          end
          if (tick_fall) begin
            sclk <= 1'b0;
            if (idx == '0) begin
              state <= TRAIL;
            end else begin
              idx  <= idx - LW'(1);
              mosi <= txsr[idx - LW'(1)];
            end
          end
        end
        TRAIL: begin
          if (phase_done) begin
            state   <= GUARD;
            cs      <= RGU_SPI_CS_IDLE;
            mosi    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rxsr;
          end
        end
        GUARD: begin
          if (phase_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgu_spi_master.sv
// Self-checking bench for rgu_spi_master: two instances (CLK_DIV 2 and 1)
// driven through a shared stimulus port and checked against a pin-level model.
module tb_rgu_spi_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, miso;
  logic [2:0]  cs_sel;
  logic [4:0]  len;
  logic [31:0] tx_data;
  int          which;

  logic        a_busy, a_done, a_sclk, a_mosi, b_busy, b_done, b_sclk, b_mosi;
  logic [7:0]  a_cs, b_cs;
  logic [31:0] a_rx, b_rx;
  logic        m_busy, m_done, m_sclk, m_mosi;
  logic [7:0]  m_cs;
  logic [31:0] m_rx;

  logic        lb;
  logic [31:0] sbits;
  logic [4:0]  sidx;

  assign miso   = lb ? m_mosi : sbits[sidx];
  assign m_busy = (which == 1) ? b_busy : a_busy;
  assign m_done = (which == 1) ? b_done : a_done;
  assign m_sclk = (which == 1) ? b_sclk : a_sclk;
  assign m_mosi = (which == 1) ? b_mosi : a_mosi;
  assign m_cs   = (which == 1) ? b_cs   : a_cs;
  assign m_rx   = (which == 1) ? b_rx   : a_rx;

  rgu_spi_master #(.DATA_W(32), .CLK_DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start && which == 0), .cs_sel(cs_sel), .len(len),
    .tx_data(tx_data), .busy(a_busy), .done(a_done), .rx_data(a_rx),
    .sclk(a_sclk), .cs(a_cs), .mosi(a_mosi), .miso(miso)
  );

  rgu_spi_master #(.DATA_W(32), .CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start && which == 1), .cs_sel(cs_sel), .len(len),
    .tx_data(tx_data), .busy(b_busy), .done(b_done), .rx_data(b_rx),
    .sclk(b_sclk), .cs(b_cs), .mosi(b_mosi), .miso(miso)
  );

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  // Pin protocol watcher on both instances: mosi frozen while sclk high, one-hot-low cs
  logic pa_sclk = 1'b0, pa_mosi = 1'b0, pb_sclk = 1'b0, pb_mosi = 1'b0;
  always @(negedge clk) begin
    if (pa_sclk === 1'b1 && a_sclk === 1'b1 && a_mosi !== pa_mosi) viol++;
    if (pb_sclk === 1'b1 && b_sclk === 1'b1 && b_mosi !== pb_mosi) viol++;
    if ($countones(~a_cs) > 1) viol++;
    if ($countones(~b_cs) > 1) viol++;
    pa_sclk = a_sclk; pa_mosi = a_mosi; pb_sclk = b_sclk; pb_mosi = b_mosi;
  end

  int          obs_busy, obs_cslow, obs_rises, obs_done, obs_done_bad;
  logic        obs_timeout, obs_first_busy, obs_first_mosi;
  logic [7:0]  obs_first_cs;
  logic [31:0] obs_rx, obs_mw;

  function automatic logic [31:0] mask_of(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // Launch one transfer and record what the pins did until busy drops.
  task automatic run_xfer(input int w, input logic [2:0] sel, input logic [4:0] lv,
                          input logic [31:0] tx, input logic lbk, input logic [31:0] sw);
    int         n;
    logic [7:0] pcs;
    logic       psclk;
    n = (lv == 5'd0) ? 32 : int'(lv);
    @(negedge clk);
    which = w; cs_sel = sel; len = lv; tx_data = tx; lb = lbk; sbits = sw;
    sidx = 5'(n - 1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs_first_busy = m_busy; obs_first_cs = m_cs; obs_first_mosi = m_mosi;
    obs_busy = 0; obs_cslow = 0; obs_rises = 0; obs_done = 0; obs_done_bad = 0;
    obs_mw = '0; obs_timeout = 1'b1; pcs = 8'hFF; psclk = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (m_busy) obs_busy++;
      if (m_cs !== 8'hFF) obs_cslow++;
      if (m_sclk && !psclk) begin
        obs_rises++;
        obs_mw = {obs_mw[30:0], m_mosi};
        if (sidx != 5'd0) sidx = sidx - 5'd1;
      end
      if (m_done) begin
        obs_done++;
        if (m_cs !== 8'hFF || pcs === 8'hFF) obs_done_bad++;
      end
      pcs = m_cs; psclk = m_sclk;
      if (!m_busy) begin
        obs_timeout = 1'b0;
        break;
      end
      cs_sel = 3'($urandom); len = 5'($urandom); tx_data = $urandom;
      @(negedge clk);
    end
    obs_rx = m_rx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    tests++; if (a_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", a_done); end
    tests++; if (a_rx !== 32'h0) begin fails++; $display("FAIL reset_rx: got %h expected 0", a_rx); end
    tests++; if (a_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b expected 0", a_sclk); end
    tests++; if (a_cs !== 8'hFF) begin fails++; $display("FAIL reset_cs: got %h expected ff", a_cs); end
    tests++; if (a_mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b expected 0", a_mosi); end
    tests++;
    if ({b_busy, b_done, b_sclk, b_mosi, b_cs, b_rx} !== {4'b0, 8'hFF, 32'h0}) begin
      fails++;
      $display("FAIL reset_b: got %b%b%b%b %h %h expected 0000 ff 0", b_busy, b_done, b_sclk, b_mosi, b_cs, b_rx);
    end
  endtask

  task automatic test_loopback();
    run_xfer(0, 3'd0, 5'd8, 32'hA5, 1'b1, 32'h0);
    tests++; if (obs_timeout) begin fails++; $display("FAIL loop_timeout: got busy stuck expected release"); end
    tests++; if (obs_first_cs !== 8'hFE) begin fails++; $display("FAIL loop_cs: got %h expected fe", obs_first_cs); end
    tests++; if (obs_first_busy !== 1'b1) begin fails++; $display("FAIL loop_busy_t1: got %b expected 1", obs_first_busy); end
    tests++; if (obs_first_mosi !== 1'b1) begin fails++; $display("FAIL loop_mosi_t1: got %b expected 1", obs_first_mosi); end
    tests++; if (obs_rises !== 8) begin fails++; $display("FAIL loop_rises: got %0d expected 8", obs_rises); end
    tests++; if (obs_rx !== 32'h0000_00A5) begin fails++; $display("FAIL loop_rx: got %h expected 000000a5", obs_rx); end
    tests++; if (obs_busy !== 38) begin fails++; $display("FAIL loop_busy_len: got %0d expected 38", obs_busy); end
    tests++; if (obs_cslow !== 36) begin fails++; $display("FAIL loop_cs_low: got %0d expected 36", obs_cslow); end
    tests++; if (obs_done !== 1 || obs_done_bad !== 0) begin fails++; $display("FAIL loop_done: got %0d (misplaced %0d) expected 1 (0)", obs_done, obs_done_bad); end
  endtask

  task automatic test_full_width();
    run_xfer(0, 3'd2, 5'd0, 32'hDEADBEEF, 1'b0, 32'h12345678);
    tests++; if (obs_rises !== 32) begin fails++; $display("FAIL full_rises: got %0d expected 32", obs_rises); end
    tests++; if (obs_mw !== 32'hDEADBEEF) begin fails++; $display("FAIL full_mosi: got %h expected deadbeef", obs_mw); end
    tests++; if (obs_rx !== 32'h12345678) begin fails++; $display("FAIL full_rx: got %h expected 12345678", obs_rx); end
    tests++; if (obs_busy !== 134) begin fails++; $display("FAIL full_busy_len: got %0d expected 134", obs_busy); end
    tests++; if (obs_first_cs !== 8'hFB) begin fails++; $display("FAIL full_cs: got %h expected fb", obs_first_cs); end
  endtask

  task automatic test_min_len();
    run_xfer(1, 3'd7, 5'd1, 32'h0, 1'b0, 32'h1);
    tests++; if (obs_first_cs !== 8'h7F) begin fails++; $display("FAIL min_cs: got %h expected 7f", obs_first_cs); end
    tests++; if (obs_rises !== 1) begin fails++; $display("FAIL min_rises: got %0d expected 1", obs_rises); end
    tests++; if (obs_rx !== 32'h1) begin fails++; $display("FAIL min_rx: got %h expected 00000001", obs_rx); end
    tests++; if (obs_busy !== 5) begin fails++; $display("FAIL min_busy_len: got %0d expected 5", obs_busy); end
    tests++; if (obs_done !== 1 || obs_done_bad !== 0) begin fails++; $display("FAIL min_done: got %0d (misplaced %0d) expected 1 (0)", obs_done, obs_done_bad); end
  endtask

  task automatic test_ignored_starts();
    int n, d, b, dones, idle, cshigh, late;
    n = 5; d = 2; b = (2 * n + 3) * d;
    dones = 0; idle = 0; cshigh = 0; late = 0;
    @(negedge clk);
    which = 0; cs_sel = 3'd4; len = 5'(n); tx_data = 32'h16; lb = 1'b1; start = 1'b1;
    for (int c = 1; c <= 2 * (b + 1); c++) begin
      @(negedge clk);
      if (m_done) dones++;
      if (!m_busy) idle++;
      if (m_cs === 8'hFF) cshigh++;
      if (c == 2 * (b + 1)) start = 1'b0;
    end
    tests++; if (dones !== 2) begin fails++; $display("FAIL spam_dones: got %0d expected 2", dones); end
    tests++; if (idle !== 2) begin fails++; $display("FAIL spam_idle_cycles: got %0d expected 2", idle); end
    tests++; if (cshigh !== 2 * (d + 1)) begin fails++; $display("FAIL spam_cs_gap: got %0d expected %0d", cshigh, 2 * (d + 1)); end
    tests++; if (m_rx !== 32'h16) begin fails++; $display("FAIL spam_rx: got %h expected 00000016", m_rx); end
    repeat (10) begin
      @(negedge clk);
      if (m_busy || m_done) late++;
    end
    tests++; if (late !== 0) begin fails++; $display("FAIL spam_queued: got %0d active cycles expected 0", late); end
  endtask

  task automatic test_reset_mid();
    int  rises, stray;
    logic ps;
    logic got3;
    rises = 0; stray = 0; ps = 1'b0; got3 = 1'b0;
    @(negedge clk);
    which = 0; cs_sel = 3'd1; len = 5'd8; tx_data = 32'h3C; lb = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (m_sclk && !ps) rises++;
      ps = m_sclk;
      if (rises == 3 && m_sclk) begin
        got3 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++; if (!got3) begin fails++; $display("FAIL rstmid_reach: got %0d rises expected 3", rises); end
    #2 rst = 1'b1;
    #1;
    tests++; if (a_cs !== 8'hFF) begin fails++; $display("FAIL rstmid_cs: got %h expected ff", a_cs); end
    tests++; if (a_sclk !== 1'b0) begin fails++; $display("FAIL rstmid_sclk: got %b expected 0", a_sclk); end
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", a_busy); end
    tests++; if (a_rx !== 32'h0) begin fails++; $display("FAIL rstmid_rx: got %h expected 0", a_rx); end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (a_done || a_busy) stray++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL rstmid_stray: got %0d active cycles expected 0", stray); end
    run_xfer(0, 3'd6, 5'd12, 32'hABC, 1'b1, 32'h0);
    tests++; if (obs_rx !== 32'hABC) begin fails++; $display("FAIL rstmid_next_rx: got %h expected 00000abc", obs_rx); end
    tests++; if (obs_busy !== 54) begin fails++; $display("FAIL rstmid_next_busy: got %0d expected 54", obs_busy); end
  endtask

  task automatic test_random();
    int          w, n, d;
    logic [2:0]  sel;
    logic [4:0]  lv;
    logic [31:0] tx, sw, exp_rx;
    logic        lbk;
    for (int i = 0; i < 100; i++) begin
      w = int'($urandom_range(0, 1)); sel = 3'($urandom); lv = 5'($urandom);
      tx = $urandom; sw = $urandom; lbk = 1'($urandom);
      n = (lv == 5'd0) ? 32 : int'(lv);
      d = (w == 1) ? 1 : 2;
      exp_rx = (lbk ? tx : sw) & mask_of(n);
      run_xfer(w, sel, lv, tx, lbk, sw);
      tests++; if (obs_timeout) begin fails++; $display("FAIL rnd%0d_timeout: got busy stuck expected release", i); end
      tests++; if (obs_rx !== exp_rx) begin fails++; $display("FAIL rnd%0d_rx: got %h expected %h", i, obs_rx, exp_rx); end
      tests++; if (obs_mw !== (tx & mask_of(n))) begin fails++; $display("FAIL rnd%0d_mosi: got %h expected %h", i, obs_mw, tx & mask_of(n)); end
      tests++; if (obs_rises !== n) begin fails++; $display("FAIL rnd%0d_rises: got %0d expected %0d", i, obs_rises, n); end
      tests++; if (obs_busy !== (2 * n + 3) * d) begin fails++; $display("FAIL rnd%0d_busy_len: got %0d expected %0d", i, obs_busy, (2 * n + 3) * d); end
      tests++; if (obs_cslow !== (2 * n + 2) * d) begin fails++; $display("FAIL rnd%0d_cs_low: got %0d expected %0d", i, obs_cslow, (2 * n + 2) * d); end
      tests++; if (obs_first_cs !== ~(8'd1 << sel)) begin fails++; $display("FAIL rnd%0d_cs: got %h expected %h", i, obs_first_cs, ~(8'd1 << sel)); end
      tests++; if (obs_first_mosi !== tx[n-1]) begin fails++; $display("FAIL rnd%0d_mosi_t1: got %b expected %b", i, obs_first_mosi, tx[n-1]); end
      tests++; if (obs_done !== 1 || obs_done_bad !== 0) begin fails++; $display("FAIL rnd%0d_done: got %0d (misplaced %0d) expected 1 (0)", i, obs_done, obs_done_bad); end
    end
    tests++; if (viol !== 0) begin fails++; $display("FAIL pin_protocol: got %0d violations expected 0", viol); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cs_sel = '0; len = '0; tx_data = '0;
    which = 0; lb = 1'b0; sbits = '0; sidx = '0;
    test_reset();
    test_loopback();
    test_full_width();
    test_min_len();
    test_ignored_starts();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgu_spi_master.md
# rgu_spi_master

Synthesizable SPI master for the RGU serial link. It drives the 8-bit active-low chip-select bus, the serial clock and `mosi`, and samples `miso`. This block is the upstream driver of the SPI pins that the RGU agent monitor observes, and its pin behaviour defines what that monitor captures. A simple start/busy/done handshake lets a register front-end launch 1–32-bit transfers to one of 8 slaves.

## Interface
Parameters:
- `DATA_W`, default 32: maximum transfer length in bits, and the width of `tx_data` and `rx_data`.
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period, and also the lead, trail and guard durations. Legal range is 1 to 255.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: request a transfer. Sampled only in IDLE.
- `cs_sel`, in, 3: index of the slave to select.
- `len`, in, $clog2(DATA_W): bit count. The value 0 encodes `DATA_W`.
- `tx_data`, in, `DATA_W`: transmit word, sent MSB-first starting at bit `len-1`.
- `busy`, out, 1: high from acceptance until the end of GUARD.
- `done`, out, 1: one-cycle pulse at transfer completion.
- `rx_data`, out, `DATA_W`: received bits, right-justified, upper bits zero. Holds its value until the next `done`.
- `sclk`, out, 1: SPI clock, CPOL=0.
- `cs`, out, 8: active-low chip selects. At most one bit is low at any time.
- `mosi`, out, 1: serial data out.
- `miso`, in, 1: serial data in.

## Operation
- Mode 0: `mosi` changes only while `sclk` is low, and is stable across each `sclk` rise. `miso` is sampled on the `clk` edge at which `sclk` goes 0→1.
- FSM states and transitions:
  - IDLE → LEAD on `start`. On this transition, latch `cs_sel`, the bit count N (1..`DATA_W`) and `tx_data` into shift registers, and clear the rx shift register.
  - LEAD (`CLK_DIV` cycles): `cs[sel]`=0, `sclk`=0, `mosi`=`tx[N-1]`. Then → SHIFT.
  - SHIFT: `sclk` toggles every `CLK_DIV` cycles, 2N half-periods in total.
    - On each rise, shift `miso` into the rx LSB.
    - On each fall except the last, present the next lower tx bit.
    - After the final fall, → TRAIL.
  - TRAIL (`CLK_DIV` cycles): `cs` still low, `sclk`=0. Then → GUARD.
  - GUARD (`CLK_DIV` cycles): `cs`=8'hFF, `mosi`=0, `busy`=1. Then → IDLE.
- On entry to GUARD:
  - `done`=1 for exactly one cycle.
  - `rx_data` loads the rx shift register.
- `start` while `busy`: ignored, not queued.
- A `start` in the same cycle that GUARD exits to IDLE is ignored. It is accepted on the first IDLE cycle.
- Simultaneous changes to `tx_data`, `len` or `cs_sel` during a transfer have no effect.
- `cs_sel` values 0..7 map to `cs` bit 0..7.
- Reset, including mid-transfer: immediately (asynchronously) apply reset values. A partial transfer produces no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `rx_data`=0, `sclk`=0, `cs`=8'hFF, `mosi`=0, FSM in IDLE, all counters 0.
- `start` sampled at edge T0. At T0+1: `busy`=1, the selected `cs` bit is 0, and `mosi` = first bit.
- Phase lengths:
  - The first `sclk` rise occurs `CLK_DIV` cycles after `cs` falls.
  - SHIFT lasts 2·N·`CLK_DIV` cycles.
  - `cs` rises `CLK_DIV` cycles after the last `sclk` fall.
- `busy` high for exactly (3 + 2N)·`CLK_DIV` cycles. `done` pulses on the cycle `cs` returns to 8'hFF.
- The minimum `cs`-high gap between back-to-back transfers is `CLK_DIV`+1 cycles.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package `rgu_spi_pkg` holds:
  - the state enum `spi_state_e` (IDLE, LEAD, SHIFT, TRAIL, GUARD);
  - `RGU_SPI_NUM_CS` = 8;
  - `RGU_SPI_CS_IDLE` = 8'hFF.
- Sub-module `rgu_spi_clkgen` contains the `CLK_DIV` prescale counter. It produces one-cycle `tick_rise`/`tick_fall` strobes and a phase-done strobe, and is enabled by the FSM.
- The top module contains the FSM, the bit counter, and the tx/rx shift registers.

## Test plan
- **Loopback:** `CLK_DIV`=2, `len`=8, `tx_data`=0xA5, `cs_sel`=0, `miso` tied to `mosi`. Expect `cs`=8'hFE, 8 `sclk` rises, `rx_data`=0x000000A5, `busy` high 38 cycles, one `done`.
- **Full width:** `len`=0, `tx_data`=0xDEADBEEF, slave model returns 0x12345678. Expect 32 rises, `mosi` sequence starting with 1,1,0,1, and `rx_data`=0x12345678.
- **Minimum length and fastest clock:** `len`=1, `CLK_DIV`=1, `cs_sel`=7, `miso`=1. Expect `cs`=8'h7F, 1 rise, `rx_data`=1, `busy` high 5 cycles.
- **Ignored starts:** `start` pulsed every cycle during a transfer, plus on the GUARD-exit cycle. Expect exactly one transfer per IDLE acceptance, and a `cs`-high gap ≥ `CLK_DIV`+1.
- **Reset mid-transfer:** assert `rst` mid-SHIFT at bit 3. Expect `cs`=8'hFF and `sclk`=0 with no clock delay, no `done`, and `rx_data`=0. The next transfer completes correctly.
- **Pin protocol check:** a checker asserts that `mosi` never changes while `sclk`=1 and that `cs` never has two bits low, across 100 random transfers.
